// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: instruction fields entering the stage and registered/writeback fields leaving it.
interface mem_wb_stage_if #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  valid_in;
    logic [DATA_W-1:0]     read_data_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [REG_ADDR_W-1:0] rd_in;
    logic                  reg_write_in;
    logic                  mem_to_reg_in;
    logic [1:0]            load_size_in;
    logic                  load_signed_in;

    logic                  valid_uit;
    logic [DATA_W-1:0]     read_data_uit;
    logic [DATA_W-1:0]     alu_result_uit;
    logic [REG_ADDR_W-1:0] rd_uit;
    logic                  wb_en_uit;
    logic [DATA_W-1:0]     wb_data_uit;

    modport master (
        output valid_in, read_data_in, alu_result_in, rd_in, reg_write_in,
               mem_to_reg_in, load_size_in, load_signed_in,
        input  valid_uit, read_data_uit, alu_result_uit, rd_uit, wb_en_uit, wb_data_uit
    );

    modport slave (
        input  valid_in, read_data_in, alu_result_in, rd_in, reg_write_in,
               mem_to_reg_in, load_size_in, load_signed_in,
        output valid_uit, read_data_uit, alu_result_uit, rd_uit, wb_en_uit, wb_data_uit
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extension, writeback select, XZR write suppression
// and saturating retire/bubble counters.
module mem_wb_stage #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             clear_counters,
    mem_wb_stage_if.slave    bus,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] bubble_count
);
    localparam logic [REG_ADDR_W-1:0] LP_ZERO_REG = REG_ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]      LP_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]      LP_CNT_ONE  = CNT_W'(1);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_read_data;
    logic [DATA_W-1:0]     r_alu_result;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic [1:0]            r_load_size;
    logic                  r_load_signed;
    logic [CNT_W-1:0]      r_retired;
    logic [CNT_W-1:0]      r_bubble;

    logic [DATA_W-1:0]     w_word_ext;
    logic [DATA_W-1:0]     w_load_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid       <= 1'b0;
            r_read_data   <= '0;
            r_alu_result  <= '0;
            r_rd          <= '0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_load_size   <= 2'b00;
            r_load_signed <= 1'b0;
        end else if (flush) begin
            r_valid       <= 1'b0;
            r_read_data   <= '0;
            r_alu_result  <= '0;
            r_rd          <= '0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_load_size   <= 2'b00;
            r_load_signed <= 1'b0;
        end else if (!stall) begin
            r_valid       <= bus.valid_in;
            r_read_data   <= bus.read_data_in;
            r_alu_result  <= bus.alu_result_in;
            r_rd          <= bus.rd_in;
            r_reg_write   <= bus.reg_write_in;
            r_mem_to_reg  <= bus.mem_to_reg_in;
            r_load_size   <= bus.load_size_in;
            r_load_signed <= bus.load_signed_in;
        end
    end

    // On a 32-bit datapath a word load is already full width.
    generate
        if (DATA_W > 32) begin : g_word_ext
            assign w_word_ext = {{(DATA_W-32){r_load_signed & r_read_data[31]}}, r_read_data[31:0]};
        end else begin : g_word_pass
            assign w_word_ext = r_read_data;
        end
    endgenerate

    always_comb begin
        w_load_ext = r_read_data;
        case (r_load_size)
            2'b00:   w_load_ext = {{(DATA_W-8){r_load_signed & r_read_data[7]}}, r_read_data[7:0]};
            2'b01:   w_load_ext = {{(DATA_W-16){r_load_signed & r_read_data[15]}}, r_read_data[15:0]};
            2'b10:   w_load_ext = w_word_ext;
            default: w_load_ext = r_read_data;
        endcase
    end

    // Counters look at the slot leaving the stage, so a flushed slot retires as a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
            r_bubble  <= '0;
        end else if (clear_counters) begin
            r_retired <= '0;
            r_bubble  <= '0;
        end else if (!stall) begin
            if (r_valid) begin
                if (r_retired != LP_CNT_MAX) r_retired <= r_retired + LP_CNT_ONE;
            end else begin
                if (r_bubble != LP_CNT_MAX) r_bubble <= r_bubble + LP_CNT_ONE;
            end
        end
    end

    assign bus.valid_uit      = r_valid;
    assign bus.read_data_uit  = r_read_data;
    assign bus.alu_result_uit = r_alu_result;
    assign bus.rd_uit         = r_rd;
    assign bus.wb_en_uit      = r_valid & r_reg_write & (r_rd != LP_ZERO_REG);
    assign bus.wb_data_uit    = r_mem_to_reg ? w_load_ext : r_alu_result;
    assign retired_count      = r_retired;
    assign bubble_count       = r_bubble;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage against a field-level reference model.
module tb_mem_wb_stage;
    localparam int DATA_W  = 64;
    localparam int RA_W    = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic clear_counters = 1'b0;
    logic [CNT_W-1:0] retired_count, bubble_count;

    int checks = 0;
    int errors = 0;

    mem_wb_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W)) bus ();

    mem_wb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .clear_counters (clear_counters),
        .bus            (bus),
        .retired_count  (retired_count),
        .bubble_count   (bubble_count)
    );

    always #5 clock = ~clock;

    // Reference model: the instruction held in the stage plus the two counts.
    logic        m_valid, m_rw, m_m2r, m_sgn;
    logic [63:0] m_rdd, m_alu;
    logic [4:0]  m_rd;
    logic [1:0]  m_size;
    int          m_ret, m_bub;

    function automatic logic [63:0] exp_wb();
        logic [63:0] mask, v;
        int bits;
        if (!m_m2r) return m_alu;
        if (m_size == 2'd3) return m_rdd;
        bits = 8 << m_size;
        mask = (64'd1 << bits) - 64'd1;
        v = m_rdd & mask;
        if (m_sgn && m_rdd[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic exp_en();
        return m_valid && m_rw && (m_rd != 5'd31);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_sgn = 0;
        m_rdd = 0; m_alu = 0; m_rd = 0; m_size = 0;
        m_ret = 0; m_bub = 0;
    endtask

    task automatic drive(input logic v, input logic [63:0] rdd, input logic [63:0] alu,
                         input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic [1:0] sz, input logic sg);
        bus.valid_in = v; bus.read_data_in = rdd; bus.alu_result_in = alu;
        bus.rd_in = rd; bus.reg_write_in = rw; bus.mem_to_reg_in = m2r;
        bus.load_size_in = sz; bus.load_signed_in = sg;
    endtask

    // One clock edge: model follows the rules using the values presented at the edge.
    task automatic tick();
        @(posedge clock);
        if (clear_counters) begin
            m_ret = 0; m_bub = 0;
        end else if (!stall) begin
            if (m_valid) m_ret = (m_ret < CNT_MAX) ? m_ret + 1 : CNT_MAX;
            else         m_bub = (m_bub < CNT_MAX) ? m_bub + 1 : CNT_MAX;
        end
        if (flush) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_sgn = 0;
            m_rdd = 0; m_alu = 0; m_rd = 0; m_size = 0;
        end else if (!stall) begin
            m_valid = bus.valid_in; m_rw = bus.reg_write_in; m_m2r = bus.mem_to_reg_in;
            m_sgn = bus.load_signed_in; m_rdd = bus.read_data_in; m_alu = bus.alu_result_in;
            m_rd = bus.rd_in; m_size = bus.load_size_in;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #12;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1, 64'hDEAD, 64'hBEEF, 5'd7, 1, 0, 2'd3, 0);
        reset = 1'b0;
        model_reset();
        #3;
        checks++; if (bus.wb_en_uit !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %0b want 0", bus.wb_en_uit); end
        checks++; if (bus.wb_data_uit !== 64'd0) begin errors++; $display("FAIL reset_wb_data got %h want 0", bus.wb_data_uit); end
        checks++; if (bus.valid_uit !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.valid_uit); end
        checks++; if (retired_count !== 4'd0 || bubble_count !== 4'd0)
            begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", retired_count, bubble_count); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_alu_writeback();
        drive(1, 64'd0, 64'h1234, 5'd3, 1, 0, 2'd0, 0);
        tick();
        checks++; if (bus.wb_en_uit !== 1'b1) begin errors++; $display("FAIL alu_wb_en got %0b want 1", bus.wb_en_uit); end
        checks++; if (bus.wb_data_uit !== 64'h1234) begin errors++; $display("FAIL alu_wb_data got %h want 1234", bus.wb_data_uit); end
        checks++; if (bus.rd_uit !== 5'd3) begin errors++; $display("FAIL alu_rd got %0d want 3", bus.rd_uit); end
        drive(0, 64'd0, 64'd0, 5'd0, 0, 0, 2'd0, 0);
        tick();
        checks++; if (retired_count !== 4'(m_ret) || m_ret != 1)
            begin errors++; $display("FAIL alu_retired got %0d want 1", retired_count); end
    endtask

    task automatic test_loads();
        logic [63:0] want [4] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_80F0,
                                  64'h0000_0000_0000_80F0, 64'h0000_0000_0000_80F0};
        logic [1:0]  sz   [4] = '{2'd0, 2'd1, 2'd1, 2'd3};
        logic        sg   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h80F0, 64'h5555, 5'd9, 1, 1, sz[i], sg[i]);
            tick();
            checks++; if (bus.wb_data_uit !== want[i])
                begin errors++; $display("FAIL load_%0d got %h want %h", i, bus.wb_data_uit, want[i]); end
        end
        drive(1, 64'hFFFF_FFFF_8000_0001, 64'h0, 5'd9, 1, 1, 2'd2, 1);
        tick();
        checks++; if (bus.wb_data_uit !== 64'hFFFF_FFFF_8000_0001)
            begin errors++; $display("FAIL load_word_signed got %h want ffffffff80000001", bus.wb_data_uit); end
        drive(1, 64'hFFFF_FFFF_8000_0001, 64'h0, 5'd9, 1, 1, 2'd2, 0);
        tick();
        checks++; if (bus.wb_data_uit !== 64'h0000_0000_8000_0001)
            begin errors++; $display("FAIL load_word_unsigned got %h want 0000000080000001", bus.wb_data_uit); end
    endtask

    task automatic test_zero_reg();
        drive(1, 64'h0, 64'hCAFE_F00D, 5'd31, 1, 0, 2'd0, 0);
        tick();
        checks++; if (bus.wb_en_uit !== 1'b0) begin errors++; $display("FAIL xzr_wb_en got %0b want 0", bus.wb_en_uit); end
        checks++; if (bus.wb_data_uit !== 64'hCAFE_F00D)
            begin errors++; $display("FAIL xzr_wb_data got %h want cafef00d", bus.wb_data_uit); end
    endtask

    task automatic test_stall_flush();
        logic [63:0] want_data;
        int want_ret, want_bub;
        drive(1, 64'h0, 64'hABCD, 5'd12, 1, 0, 2'd0, 0);
        tick();
        want_data = 64'hABCD; want_ret = m_ret; want_bub = m_bub;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            tick();
            checks++; if (bus.wb_data_uit !== want_data || bus.rd_uit !== 5'd12 || bus.wb_en_uit !== 1'b1)
                begin errors++; $display("FAIL stall_hold_%0d got %h/%0d/%0b want %h/12/1", i,
                                         bus.wb_data_uit, bus.rd_uit, bus.wb_en_uit, want_data); end
            checks++; if (retired_count !== 4'(want_ret) || bubble_count !== 4'(want_bub))
                begin errors++; $display("FAIL stall_counters_%0d got %0d/%0d want %0d/%0d", i,
                                         retired_count, bubble_count, want_ret, want_bub); end
        end
        flush = 1'b1;
        tick();
        checks++; if (bus.valid_uit !== 1'b0 || bus.wb_en_uit !== 1'b0)
            begin errors++; $display("FAIL stall_flush got v=%0b en=%0b want 0/0", bus.valid_uit, bus.wb_en_uit); end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(1, 64'h0, 64'h77, 5'd4, 1, 0, 2'd0, 0);
        tick();
        tick();
        checks++; if (bus.wb_en_uit !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b want 1", bus.wb_en_uit); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.wb_en_uit !== 1'b0 || bus.valid_uit !== 1'b0)
            begin errors++; $display("FAIL areset_wb_en got %0b/%0b want 0/0", bus.wb_en_uit, bus.valid_uit); end
        checks++; if (retired_count !== 4'd0 || bubble_count !== 4'd0)
            begin errors++; $display("FAIL areset_counters got %0d/%0d want 0/0", retired_count, bubble_count); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1, 64'h0, 64'(i), 5'd1, 1, 0, 2'd0, 0);
            tick();
        end
        checks++; if (retired_count !== 4'd15 || m_ret != 15)
            begin errors++; $display("FAIL sat_retired got %0d want 15", retired_count); end
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        checks++; if (retired_count !== 4'd0 || bubble_count !== 4'd0)
            begin errors++; $display("FAIL sat_clear got %0d/%0d want 0/0", retired_count, bubble_count); end
    endtask

    task automatic test_random();
        logic [4:0] rds [4] = '{5'd0, 5'd5, 5'd30, 5'd31};
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            clear_counters = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
                  rds[$urandom_range(0, 3)], 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            tick();
            checks++; if (bus.wb_data_uit !== exp_wb() || bus.wb_en_uit !== exp_en() || bus.valid_uit !== m_valid)
                begin errors++; $display("FAIL rand_out_%0d got %h/%0b/%0b want %h/%0b/%0b", i, bus.wb_data_uit,
                                         bus.wb_en_uit, bus.valid_uit, exp_wb(), exp_en(), m_valid); end
            checks++; if (retired_count !== 4'(m_ret) || bubble_count !== 4'(m_bub))
                begin errors++; $display("FAIL rand_cnt_%0d got %0d/%0d want %0d/%0d", i,
                                         retired_count, bubble_count, m_ret, m_bub); end
        end
        stall = 1'b0; flush = 1'b0; clear_counters = 1'b0;
    endtask

    initial begin
        drive(0, 64'd0, 64'd0, 5'd0, 0, 0, 2'd0, 0);
        test_reset();
        do_reset();
        test_alu_writeback();
        test_loads();
        test_zero_reg();
        test_stall_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the pipelined ARMv8 core. It sits between the data-memory stage and register-file writeback. It carries load data, the ALU result and writeback control, and adds valid tracking, stall/flush control, load size/sign extension, writeback-data selection, zero-register write suppression and saturating retire/bubble counters.

Parameters:
DATA_W, 64, datapath width; legal values 32 or 64.
REG_ADDR_W, 5, destination register index width.
ZERO_REG, 31, register index whose writes are suppressed (XZR).
CNT_W, 32, width of each performance counter.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold all stage registers
flush  input  1  replace the captured instruction with a bubble
clear_counters  input  1  synchronous zero of both counters
valid_in  input  1  MEM stage holds a real instruction
read_data_in  input  DATA_W  data-memory read data, aligned to bit 0
alu_result_in  input  DATA_W  ALU result / address
rd_in  input  REG_ADDR_W  destination register
reg_write_in  input  1  instruction writes the register file
mem_to_reg_in  input  1  1 = writeback load data, 0 = ALU result
load_size_in  input  2  00 byte, 01 half, 10 word, 11 double
load_signed_in  input  1  sign-extend the load
valid_uit  output  1  registered valid
read_data_uit  output  DATA_W  registered raw read data
alu_result_uit  output  DATA_W  registered ALU result
rd_uit  output  REG_ADDR_W  registered destination
wb_en_uit  output  1  register-file write enable
wb_data_uit  output  DATA_W  register-file write data
retired_count  output  CNT_W  instructions that left the stage
bubble_count  output  CNT_W  empty slots that left the stage

Behaviour:
- Reset (reset = 0, asynchronous): all registers, including valid, control and data, go to 0. Both counters go to 0. Effects on outputs:
  - wb_en_uit = 0.
  - wb_data_uit = 0.
- Release of reset is synchronised by the environment. The block samples inputs on the first rising edge with reset = 1.
- Update priority on each rising edge: flush > stall > load.
  - flush = 1: valid, reg_write, mem_to_reg, load_size, load_signed, rd and both data registers are cleared to 0. Flush wins over a simultaneous stall.
  - stall = 1 (flush = 0): every stage register holds.
  - Otherwise: every stage register captures its *_in value. Latency is 1 cycle.
- wb_data_uit is combinational from the registers, with no added latency:
  - mem_to_reg_reg = 0: wb_data_uit = alu_result_uit.
  - mem_to_reg_reg = 1: wb_data_uit = the extended read_data_uit.
    - Byte uses bits [7:0]; half uses [15:0]; word uses [31:0].
    - load_signed = 1: replicate the top kept bit; otherwise zero-fill.
    - Size 11 passes the full DATA_W and ignores signed.
    - When DATA_W = 32, size 10 and 11 both pass the full width.
- wb_en_uit = valid_uit & reg_write_reg & (rd_uit != ZERO_REG). A write to ZERO_REG never asserts enable, but wb_data_uit is still driven.
- wb_en_uit stays asserted while stalled. The repeated identical write is allowed.
- Counters (registered, each saturating at 2^CNT_W-1 with no wrap):
  - retired_count increments on an edge where valid_uit = 1 and stall = 0.
  - bubble_count increments on an edge where valid_uit = 0 and stall = 0.
  - A flushed slot counts as a bubble when it leaves.
  - clear_counters = 1 forces both counters to 0 on that edge. It has priority over increment and is independent of stall and flush.
- A reset asserted mid-operation drops any in-flight instruction; no write enable is produced for it.

Test Plan:
- Reset, then present valid_in = 1, alu_result_in = 0x1234, rd_in = 3, reg_write_in = 1, mem_to_reg_in = 0 -> after one edge: wb_en_uit = 1, wb_data_uit = 0x1234, rd_uit = 3. retired_count = 1 one edge later.
- Load tests with read_data_in = 0x00000000_0000_80F0, mem_to_reg_in = 1:
  - size 00, signed -> wb_data_uit = 0xFFFF_FFFF_FFFF_FFF0.
  - size 01, signed -> wb_data_uit = 0xFFFF_FFFF_FFFF_80F0.
  - size 01, unsigned -> wb_data_uit = 0x0000_0000_0000_80F0.
  - size 11 -> wb_data_uit = 0x80F0.
- rd_in = 31, reg_write_in = 1, valid_in = 1 -> wb_en_uit = 0 and wb_data_uit still equals the ALU result.
- Capture an instruction, hold stall = 1 for 3 edges while the inputs change -> outputs unchanged and counters unchanged. Then assert stall = 1 together with flush = 1 -> valid_uit = 0 and wb_en_uit = 0.
- Drive reset low asynchronously between edges while valid_uit = 1 -> wb_en_uit = 0 and counters = 0 immediately, without waiting for a clock edge.
- With CNT_W = 4, run 20 valid non-stalled cycles -> retired_count saturates at 15. Then clear_counters = 1 -> retired_count = 0 and bubble_count = 0.
